// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: pooling mode encodings, a signed max helper
// and bit-slice index helpers for packed pixel buses.
package cnn_pkg;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    localparam int SMAX_W = 64;

    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // LSB of row r, channel c on a bus holding ch channels per row
    function automatic int pix_lsb(input int r, input int c, input int ch, input int dw);
        return (r * ch + c) * dw;
    endfunction

    function automatic int chan_lsb(input int c, input int dw);
        return c * dw;
    endfunction

endpackage

// File: rtl/pool_window_unit_col_reduce.sv
// Registered reduction of one channel's POOL_K vertically adjacent pixels into a
// single column value: signed max, or signed sum widened by LOG2K bits.
module pool_col_reduce
    import cnn_pkg::*;
#(
    parameter int DW = 22,
    parameter int POOL_K = 2,
    localparam int LOG2K = $clog2(POOL_K)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic                        mode,
    input  logic [POOL_K*DW-1:0]        rows,
    output logic signed [DW+LOG2K-1:0]  col
);

    localparam int CW = DW + LOG2K;

    logic signed [CW-1:0] max_w;
    logic signed [CW-1:0] sum_w;
    logic signed [CW-1:0] pix_w;
    logic signed [CW-1:0] col_d;
    logic signed [CW-1:0] col_q;

    always_comb begin
        max_w = CW'($signed(rows[DW-1:0]));
        sum_w = max_w;
        pix_w = max_w;
        for (int r = 1; r < POOL_K; r++) begin
            pix_w = CW'($signed(rows[r*DW +: DW]));
            // smax works at a fixed wide width; compare its result to pick the narrow operand
            max_w = (smax(SMAX_W'(max_w), SMAX_W'(pix_w)) == SMAX_W'(max_w)) ? max_w : pix_w;
            sum_w = sum_w + pix_w;
        end
        col_d = (mode == POOL_AVG) ? sum_w : max_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
        end else if (load) begin
            col_q <= col_d;
        end
    end

    assign col = col_q;

endmodule

// File: rtl/pool_window_unit.sv
// Streaming POOL_K x POOL_K pooling stage: column reduce, column accumulate and
// a held output register, all advancing together under valid/ready backpressure.
module pool_window_unit
    import cnn_pkg::*;
#(
    parameter int DW = 22,
    parameter int POOL_K = 2,
    parameter int CH = 1,
    localparam int LOG2K = $clog2(POOL_K)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [POOL_K*CH*DW-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*DW-1:0]         out_data
);

    localparam int CW = DW + LOG2K;
    localparam int AW = DW + 2 * LOG2K;

    logic             en;
    logic             in_fire;
    logic             s1_fold;
    logic             last_col;
    logic             beat_mode;
    logic [LOG2K-1:0] in_cnt_q, in_cnt_d;
    logic [LOG2K-1:0] col_cnt_q, col_cnt_d;
    logic             in_mode_q, in_mode_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_mode_q, s1_mode_d;
    logic             out_valid_q, out_valid_d;
    logic [CH*DW-1:0] out_data_q, out_data_d;
    logic signed [AW-1:0] acc_q [CH];
    logic signed [AW-1:0] acc_d [CH];
    logic signed [CW-1:0] col_val [CH];
    logic signed [AW-1:0] col_x;
    logic signed [AW-1:0] fold_x;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en && !clr;
    assign in_fire   = in_valid && in_ready;
    assign s1_fold   = en && s1_valid_q && !clr;
    assign last_col  = (col_cnt_q == LOG2K'(POOL_K - 1));
    // The input side tracks its own column index so stage 1 reduces every
    // column of a window with the mode captured on that window's first beat.
    assign beat_mode = (in_cnt_q == '0) ? mode : in_mode_q;

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [POOL_K*DW-1:0] rows;
            for (genvar gr = 0; gr < POOL_K; gr++) begin : g_row
                assign rows[gr*DW +: DW] = in_data[pix_lsb(gr, gi, CH, DW) +: DW];
            end
            pool_col_reduce #(
                .DW     (DW),
                .POOL_K (POOL_K)
            ) u_reduce (
                .clk  (clk),
                .rst  (rst),
                .load (in_fire),
                .mode (beat_mode),
                .rows (rows),
                .col  (col_val[gi])
            );
        end
    endgenerate

    always_comb begin
        in_cnt_d    = in_cnt_q;
        col_cnt_d   = col_cnt_q;
        in_mode_d   = in_mode_q;
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        col_x       = '0;
        fold_x      = '0;
        for (int c = 0; c < CH; c++) begin
            acc_d[c] = acc_q[c];
        end

        if (in_fire) begin
            in_cnt_d = in_cnt_q + LOG2K'(1);
            if (in_cnt_q == '0) begin
                in_mode_d = mode;
            end
        end

        if (en) begin
            s1_valid_d  = in_fire;
            s1_mode_d   = in_fire ? beat_mode : s1_mode_q;
            out_valid_d = s1_fold && last_col;
        end

        if (s1_fold) begin
            col_cnt_d = col_cnt_q + LOG2K'(1);
            for (int c = 0; c < CH; c++) begin
                col_x = AW'(col_val[c]);
                if (col_cnt_q == '0) begin
                    fold_x = col_x;
                end else if (s1_mode_q == POOL_AVG) begin
                    fold_x = acc_q[c] + col_x;
                end else begin
                    fold_x = (smax(SMAX_W'(acc_q[c]), SMAX_W'(col_x)) == SMAX_W'(acc_q[c]))
                             ? acc_q[c] : col_x;
                end
                acc_d[c] = fold_x;
                if (last_col) begin
                    // Arithmetic shift floors toward -inf; the mean always fits in DW.
                    out_data_d[chan_lsb(c, DW) +: DW] = (s1_mode_q == POOL_AVG)
                        ? DW'(fold_x >>> (2 * LOG2K)) : DW'(fold_x);
                end
            end
        end

        if (clr) begin
            in_cnt_d   = '0;
            col_cnt_d  = '0;
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q    <= '0;
            col_cnt_q   <= '0;
            in_mode_q   <= POOL_MAX;
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= POOL_MAX;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            in_cnt_q    <= in_cnt_d;
            col_cnt_q   <= col_cnt_d;
            in_mode_q   <= in_mode_d;
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int c = 0; c < CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_pool_window_unit.sv
// Directed and scoreboard checks of pool_window_unit: a default K=2/CH=1
// instance for hand-computed windows and a K=4/CH=3 instance for a random stream.
module tb_pool_window_unit;

    localparam int DW  = 22;
    localparam int K4  = 4;
    localparam int CH4 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic              mode0, clr0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [2*DW-1:0]   in_data0;
    logic [DW-1:0]     out_data0;

    logic                   mode4, clr4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [K4*CH4*DW-1:0]   in_data4;
    logic [CH4*DW-1:0]      out_data4;

    pool_window_unit u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode0),
        .clr       (clr0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0)
    );

    pool_window_unit #(.DW(DW), .POOL_K(K4), .CH(CH4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode4),
        .clr       (clr4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4)
    );

    int checks = 0;
    int errors = 0;

    logic [K4*CH4*DW-1:0] wcols [K4];
    int                   wcnt = 0;
    logic                 wmode = 1'b0;
    logic [CH4*DW-1:0]    expq [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] e22(input int v);
        logic [DW-1:0] t;
        t = v[DW-1:0];
        return 128'(t);
    endfunction

    function automatic logic [2*DW-1:0] col2(input int top, input int bot);
        return {bot[DW-1:0], top[DW-1:0]};
    endfunction

    function automatic longint pix4(input logic [K4*CH4*DW-1:0] d, input int r, input int c);
        logic signed [DW-1:0] p;
        p = d[(r*CH4+c)*DW +: DW];
        return longint'(p);
    endfunction

    // Flat reference over all K*K pixels of a window, per channel.
    task automatic model_push(input logic [K4*CH4*DW-1:0] d, input logic m);
        logic [CH4*DW-1:0] e;
        longint mx, sm, p, res;
        if (wcnt == 0) wmode = m;
        wcols[wcnt] = d;
        wcnt++;
        if (wcnt == K4) begin
            e = '0;
            for (int c = 0; c < CH4; c++) begin
                mx = pix4(wcols[0], 0, c);
                sm = 0;
                for (int k = 0; k < K4; k++) begin
                    for (int r = 0; r < K4; r++) begin
                        p = pix4(wcols[k], r, c);
                        if (p > mx) mx = p;
                        sm += p;
                    end
                end
                res = wmode ? (sm >>> 4) : mx;
                e[c*DW +: DW] = res[DW-1:0];
            end
            expq.push_back(e);
            wcnt = 0;
        end
    endtask

    task automatic take4();
        if (expq.size() == 0) begin
            chk("rand_unexpected_out", 128'(expq.size()), 128'(1));
        end else begin
            chk("rand_out", 128'(out_data4), 128'(expq.pop_front()));
        end
    endtask

    task automatic send0(input int top, input int bot, input logic m);
        int n = 0;
        in_data0  = col2(top, bot);
        mode0     = m;
        in_valid0 = 1'b1;
        #1;
        while (!in_ready0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("send0_ready", 128'(in_ready0), 128'(1));
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    task automatic send4(input logic [K4*CH4*DW-1:0] d, input logic m);
        int n = 0;
        in_data4  = d;
        mode4     = m;
        in_valid4 = 1'b1;
        #1;
        while (!in_ready4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("send4_ready", 128'(in_ready4), 128'(1));
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_ov4();
        int n = 0;
        while (!out_valid4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [K4*CH4*DW-1:0] rand_col4();
        logic [K4*CH4*DW-1:0] d;
        for (int i = 0; i < K4 * CH4; i++) d[i*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    // Two columns; result expected one cycle after the second beat's accept edge.
    task automatic run_win0(input string tag, input logic m0, input logic m1,
                            input int t0, input int b0, input int t1, input int b1,
                            input int exp);
        send0(t0, b0, m0);
        send0(t1, b1, m1);
        chk({tag, "_early"}, 128'(out_valid0), 128'(0));
        @(posedge clk); #1;
        chk({tag, "_valid"}, 128'(out_valid0), 128'(1));
        chk({tag, "_data"}, 128'(out_data0), e22(exp));
        @(posedge clk); #1;
        chk({tag, "_drop"}, 128'(out_valid0), 128'(0));
    endtask

    initial begin
        int ncols = 0;
        int cyc = 0;
        logic [K4*CH4*DW-1:0] d;

        rst = 1'b1;
        mode0 = 1'b0; clr0 = 1'b0; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b1;
        mode4 = 1'b0; clr4 = 1'b0; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid0), 128'(0));
        chk("rst_out_data", 128'(out_data0), 128'(0));
        chk("rst_out_valid4", 128'(out_valid4), 128'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready0), 128'(1));
        @(posedge clk); #1;

        run_win0("max",     1'b0, 1'b0,  3, -5,  7,  2,  7);
        run_win0("max_neg", 1'b0, 1'b0, -4, -9, -1, -8, -1);
        run_win0("ties",    1'b0, 1'b0,  5,  5,  5,  5,  5);
        run_win0("avg_neg", 1'b1, 1'b1,  1,  2,  3, -7, -1);
        run_win0("avg_pos", 1'b1, 1'b1,  4,  4,  4,  5,  4);
        run_win0("flip_ma", 1'b0, 1'b1,  1,  2,  3, -7,  3);
        run_win0("flip_am", 1'b1, 1'b0,  4,  4,  4,  5,  4);

        // Backpressure: hold the result for 5 cycles with a beat waiting.
        out_ready0 = 1'b0;
        send0(3, -5, 1'b0);
        send0(7, 2, 1'b0);
        @(posedge clk); #1;
        chk("bp_valid", 128'(out_valid0), 128'(1));
        in_data0  = col2(10, 1);
        mode0     = 1'b0;
        in_valid0 = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", 128'(out_data0), e22(7));
            chk("bp_in_ready", 128'(in_ready0), 128'(0));
            @(posedge clk); #1;
        end
        out_ready0 = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready0), 128'(1));
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        chk("bp_taken", 128'(out_valid0), 128'(0));
        send0(2, 11, 1'b0);
        chk("bp_next_early", 128'(out_valid0), 128'(0));
        @(posedge clk); #1;
        chk("bp_next_valid", 128'(out_valid0), 128'(1));
        chk("bp_next_data", 128'(out_data0), e22(11));
        @(posedge clk); #1;

        // Clear after one column, with a beat offered during the clear.
        send0(100, 50, 1'b0);
        clr0      = 1'b1;
        in_data0  = col2(90, 90);
        in_valid0 = 1'b1;
        @(posedge clk); #1;
        clr0      = 1'b0;
        in_valid0 = 1'b0;
        chk("clr_no_out0", 128'(out_valid0), 128'(0));
        @(posedge clk); #1;
        chk("clr_no_out1", 128'(out_valid0), 128'(0));
        run_win0("clr_next", 1'b0, 1'b0, 6, 2, 1, 3, 6);

        // Random stream on the K=4, CH=3 instance against the scoreboard.
        while (ncols < 400 && cyc < 4000) begin
            in_valid4  = ($urandom_range(3) != 0);
            mode4      = 1'($urandom_range(1));
            out_ready4 = ($urandom_range(2) != 0);
            in_data4   = rand_col4();
            #1;
            if (out_valid4 && out_ready4) take4();
            if (in_valid4 && in_ready4) begin
                model_push(in_data4, mode4);
                ncols++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (ncols < 400) chk("rand_cols", 128'(ncols), 128'(400));
        in_valid4  = 1'b0;
        out_ready4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid4) take4();
            @(posedge clk); #1;
        end
        chk("rand_drained", 128'(expq.size()), 128'(0));

        // Reset mid-window while a result is pending.
        out_ready4 = 1'b0;
        for (int i = 0; i < 5; i++) send4(rand_col4(), 1'b0);
        wait_ov4();
        chk("rst_pre_valid", 128'(out_valid4), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", 128'(out_valid4), 128'(0));
        chk("rst_async_data", 128'(out_data4), 128'(0));
        #2 rst = 1'b0;
        wcnt = 0;
        expq.delete();
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < K4; i++) begin
            d = rand_col4();
            send4(d, 1'b1);
            model_push(d, 1'b1);
        end
        wait_ov4();
        chk("rst_realign_valid", 128'(out_valid4), 128'(1));
        if (expq.size() != 0) chk("rst_realign_data", 128'(out_data4), 128'(expq.pop_front()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
